// File: rtl/turf_rdwr_pkg.sv
// Shared types and field positions for the UDP read/write control sequencer.
package turf_rdwr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DROP  = 3'd1,
    HDR   = 3'd2,
    FETCH = 3'd3,
    ACC   = 3'd4,
    OUT   = 3'd5
  } state_t;

  // Bit positions inside s_axis_tuser
  localparam int TU_READ = 0;
  localparam int TU_HDR  = 1;
  localparam int TU_LO   = 2;
  localparam int TU_HI   = 3;

  localparam int ADDR_W      = 28;
  localparam int DATA_W      = 32;
  localparam int PL_ADDR_LSB = 0;
  localparam int PL_DATA_LSB = 32;

  function automatic logic [63:0] pack_payload(input logic [DATA_W-1:0] data,
                                               input logic [ADDR_W-1:0] addr);
    logic [63:0] word;
    word = '0;
    word[PL_DATA_LSB +: DATA_W] = data;
    word[PL_ADDR_LSB +: ADDR_W] = addr;
    return word;
  endfunction

endpackage

// File: rtl/turf_rdwr_acc.sv
// Single-access engine for the en/wr/ack bus: holds the request until ack or
// until the ack timeout expires, then pulses done with the captured data.
module turf_rdwr_acc
  import turf_rdwr_pkg::*;
#(
  parameter int          ACK_TIMEOUT  = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hFFFFFFFF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] dat,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              en_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  output logic              done,
  output logic              timed_out,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic              en_reg;
  logic              wr_reg;
  logic [ADDR_W-1:0] adr_reg;
  logic [DATA_W-1:0] dat_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              done_reg;
  logic              tmo_reg;
  logic [DATA_W-1:0] rd_data_reg;

  // en_reg is high for at most ACK_TIMEOUT cycles; ack is only honoured while it is high
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_reg      <= 1'b0;
      wr_reg      <= 1'b0;
      adr_reg     <= '0;
      dat_reg     <= '0;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
      tmo_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      tmo_reg  <= 1'b0;
      if (start) begin
        en_reg  <= 1'b1;
        wr_reg  <= wr;
        adr_reg <= adr;
        dat_reg <= dat;
        cnt_reg <= '0;
      end else if (en_reg) begin
        if (ack_i) begin
          en_reg      <= 1'b0;
          done_reg    <= 1'b1;
          rd_data_reg <= dat_i;
        end else if (cnt_reg == CNT_W'(ACK_TIMEOUT - 1)) begin
          en_reg      <= 1'b0;
          done_reg    <= 1'b1;
          tmo_reg     <= 1'b1;
          rd_data_reg <= TIMEOUT_DATA;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign en_o      = en_reg;
  assign wr_o      = wr_reg;
  assign adr_o     = adr_reg;
  assign dat_o     = dat_reg;
  assign done      = done_reg;
  assign timed_out = tmo_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: rtl/turf_rdwr_ctrl.sv
// Control-port sequencer: turns merged header/payload request words into single
// bus accesses and emits a response header plus one payload word per access.
module turf_rdwr_ctrl
  import turf_rdwr_pkg::*;
#(
  parameter int          ACK_TIMEOUT  = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hFFFFFFFF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [63:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [3:0]        s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic [63:0]       m_hdr_tdata,
  output logic              m_hdr_tvalid,
  input  logic              m_hdr_tready,
  output logic              m_hdr_tuser,
  output logic [63:0]       m_payload_tdata,
  output logic              m_payload_tvalid,
  input  logic              m_payload_tready,
  output logic [7:0]        m_payload_tkeep,
  output logic              m_payload_tlast,
  output logic              en_o,
  output logic              wr_o,
  input  logic              ack_i,
  output logic [ADDR_W-1:0] adr_o,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic [15:0]       timeout_count_o
);

  state_t state_reg, state_next;

  logic [31:0]       ip_reg;
  logic [15:0]       port_reg;
  logic [15:0]       len_reg;
  logic              rd_reg;
  logic              hdr_last_reg;
  logic [ADDR_W-1:0] hi_adr_reg;
  logic              hi_pend_reg;
  logic              word_last_reg;
  logic [63:0]       pl_data_reg;
  logic              pl_last_reg;
  logic [15:0]       tmo_cnt_reg;

  logic              ready_int;
  logic              fetch_go;
  logic              acc_start;
  logic [ADDR_W-1:0] acc_adr;
  logic              acc_done;
  logic              acc_tmo;
  logic [DATA_W-1:0] acc_rd_data;
  logic              unused_bits;

  // Writes need the full word (address + data); reads need at least one half
  assign fetch_go = rd_reg ? (s_axis_tuser[TU_LO] | s_axis_tuser[TU_HI])
                           : (s_axis_tuser[TU_LO] & s_axis_tuser[TU_HI]);

  assign acc_adr = (state_reg != FETCH)              ? hi_adr_reg :
                   (rd_reg && !s_axis_tuser[TU_LO])  ? s_axis_tdata[32 +: ADDR_W] :
                                                       s_axis_tdata[0 +: ADDR_W];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready_int  = 1'b0;
    acc_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_int = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tuser[TU_HDR]) state_next = HDR;
          else if (!s_axis_tlast)   state_next = DROP;
        end
      end
      DROP: begin
        ready_int = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_next = IDLE;
      end
      HDR: begin
        if (m_hdr_tready) state_next = hdr_last_reg ? IDLE : FETCH;
      end
      FETCH: begin
        ready_int = 1'b1;
        if (s_axis_tvalid) begin
          if (fetch_go) begin
            state_next = ACC;
            acc_start  = 1'b1;
          end else if (s_axis_tlast) begin
            state_next = IDLE;
          end
        end
      end
      ACC: begin
        if (acc_done) state_next = OUT;
      end
      OUT: begin
        if (m_payload_tready) begin
          if (hi_pend_reg) begin
            state_next = ACC;
            acc_start  = 1'b1;
          end else if (word_last_reg) begin
            state_next = IDLE;
          end else begin
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ip_reg        <= '0;
      port_reg      <= '0;
      len_reg       <= '0;
      rd_reg        <= 1'b0;
      hdr_last_reg  <= 1'b0;
      hi_adr_reg    <= '0;
      hi_pend_reg   <= 1'b0;
      word_last_reg <= 1'b0;
      pl_data_reg   <= '0;
      pl_last_reg   <= 1'b0;
      tmo_cnt_reg   <= '0;
    end else begin
      if (state_reg == IDLE && s_axis_tvalid && s_axis_tuser[TU_HDR]) begin
        ip_reg       <= s_axis_tdata[63:32];
        port_reg     <= s_axis_tdata[31:16];
        rd_reg       <= s_axis_tuser[TU_READ];
        // Each read returns two 32-bit response words per requested word
        len_reg      <= s_axis_tuser[TU_READ] ? {s_axis_tdata[14:0], 1'b0}
                                              : s_axis_tdata[15:0];
        hdr_last_reg <= s_axis_tlast;
      end
      if (state_reg == FETCH && s_axis_tvalid && fetch_go) begin
        hi_adr_reg    <= s_axis_tdata[32 +: ADDR_W];
        hi_pend_reg   <= rd_reg & s_axis_tuser[TU_LO] & s_axis_tuser[TU_HI];
        word_last_reg <= s_axis_tlast;
      end
      if (state_reg == ACC && acc_done) begin
        pl_data_reg <= pack_payload(rd_reg ? acc_rd_data : dat_o, adr_o);
        pl_last_reg <= word_last_reg & ~hi_pend_reg;
        if (acc_tmo && tmo_cnt_reg != 16'hFFFF) tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
      end
      if (state_reg == OUT && m_payload_tready && hi_pend_reg) hi_pend_reg <= 1'b0;
    end
  end

  turf_rdwr_acc #(
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .TIMEOUT_DATA (TIMEOUT_DATA)
  ) u_acc (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (acc_start),
    .wr        (~rd_reg),
    .adr       (acc_adr),
    .dat       (s_axis_tdata[63:32]),
    .ack_i     (ack_i),
    .dat_i     (dat_i),
    .en_o      (en_o),
    .wr_o      (wr_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .done      (acc_done),
    .timed_out (acc_tmo),
    .rd_data   (acc_rd_data)
  );

  assign s_axis_tready    = ready_int & aresetn;
  assign m_hdr_tvalid     = (state_reg == HDR);
  assign m_hdr_tdata      = {ip_reg, port_reg, len_reg};
  assign m_hdr_tuser      = rd_reg;
  assign m_payload_tvalid = (state_reg == OUT);
  assign m_payload_tdata  = pl_data_reg;
  assign m_payload_tlast  = pl_last_reg;
  assign timeout_count_o  = tmo_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_keep
      assign m_payload_tkeep[gi] = 1'b1;
    end
  endgenerate

  assign unused_bits = &{1'b0, s_axis_tdata[31:28]};

endmodule

// File: tb/tb_turf_rdwr_ctrl.sv
// Directed bench for turf_rdwr_ctrl with a responding memory model and
// response/access recorders.
module tb_turf_rdwr_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [3:0]  s_axis_tuser;
  logic        s_axis_tlast;
  logic [63:0] m_hdr_tdata;
  logic        m_hdr_tvalid;
  logic        m_hdr_tready;
  logic        m_hdr_tuser;
  logic [63:0] m_payload_tdata;
  logic        m_payload_tvalid;
  logic        m_payload_tready;
  logic [7:0]  m_payload_tkeep;
  logic        m_payload_tlast;
  logic        en_o;
  logic        wr_o;
  logic        ack_i = 1'b0;
  logic [27:0] adr_o;
  logic [31:0] dat_i = 32'h0;
  logic [31:0] dat_o;
  logic [15:0] timeout_count_o;

  always #5 aclk = ~aclk;

  turf_rdwr_ctrl #(
    .ACK_TIMEOUT  (255),
    .TIMEOUT_DATA (32'hFFFFFFFF)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tlast     (s_axis_tlast),
    .m_hdr_tdata      (m_hdr_tdata),
    .m_hdr_tvalid     (m_hdr_tvalid),
    .m_hdr_tready     (m_hdr_tready),
    .m_hdr_tuser      (m_hdr_tuser),
    .m_payload_tdata  (m_payload_tdata),
    .m_payload_tvalid (m_payload_tvalid),
    .m_payload_tready (m_payload_tready),
    .m_payload_tkeep  (m_payload_tkeep),
    .m_payload_tlast  (m_payload_tlast),
    .en_o             (en_o),
    .wr_o             (wr_o),
    .ack_i            (ack_i),
    .adr_o            (adr_o),
    .dat_i            (dat_i),
    .dat_o            (dat_o),
    .timeout_count_o  (timeout_count_o)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [64:0] hdr_q[$];
  logic [64:0] pl_q[$];
  logic [64:0] acc_q[$];
  logic        ack_en = 1'b1;
  int          en_cycles = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Recorder and memory model; ack answers one cycle after en_o is seen
  always @(negedge aclk) begin
    if (m_hdr_tvalid && m_hdr_tready) begin
      hdr_q.push_back({m_hdr_tuser, m_hdr_tdata});
      $display("hdr     user=%0b data=%h", m_hdr_tuser, m_hdr_tdata);
    end
    if (m_payload_tvalid && m_payload_tready) begin
      pl_q.push_back({m_payload_tlast, m_payload_tdata});
      $display("payload last=%0b data=%h", m_payload_tlast, m_payload_tdata);
    end
    if (en_o) en_cycles++;
    if (en_o && ack_en && !ack_i) begin
      ack_i = 1'b1;
      dat_i = 32'hD000_0000 | {4'h0, adr_o};
      acc_q.push_back({wr_o, (wr_o ? dat_o : 32'h0), 4'h0, adr_o});
      $display("access  wr=%0b adr=%h dat=%h", wr_o, adr_o, dat_o);
    end else begin
      ack_i = 1'b0;
    end
  end

  function automatic logic [64:0] q_at(input int which, input int i);
    logic [64:0] v;
    v = 65'h1_DEAD_DEAD_DEAD_DEAD;
    case (which)
      0: if (i < hdr_q.size()) v = hdr_q[i];
      1: if (i < pl_q.size())  v = pl_q[i];
      default: if (i < acc_q.size()) v = acc_q[i];
    endcase
    return v;
  endfunction

  task automatic send_word(input logic [63:0] d, input logic [3:0] u, input logic l);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    check("send_ready", {64'h0, s_axis_tready}, 65'h1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_for(input int nh, input int np);
    int n;
    n = 0;
    while ((hdr_q.size() < nh || pl_q.size() < np) && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    repeat (4) @(negedge aclk);
    check("n_hdr", 65'(hdr_q.size()), 65'(nh));
    check("n_pl", 65'(pl_q.size()), 65'(np));
  endtask

  task automatic clear_q();
    @(posedge aclk);
    #1;
    hdr_q.delete();
    pl_q.delete();
    acc_q.delete();
  endtask

  initial begin
    logic        hold_ok;
    logic [63:0] first_data;
    int          n;

    aresetn          = 1'b0;
    s_axis_tdata     = '0;
    s_axis_tvalid    = 1'b0;
    s_axis_tuser     = '0;
    s_axis_tlast     = 1'b0;
    m_hdr_tready     = 1'b1;
    m_payload_tready = 1'b1;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_en", {64'h0, en_o}, 65'h0);
    check("rst_wr", {64'h0, wr_o}, 65'h0);
    check("rst_tready", {64'h0, s_axis_tready}, 65'h0);
    check("rst_hvalid", {64'h0, m_hdr_tvalid}, 65'h0);
    check("rst_pvalid", {64'h0, m_payload_tvalid}, 65'h0);
    check("rst_adr", 65'(adr_o), 65'h0);
    check("rst_dat", 65'(dat_o), 65'h0);
    check("rst_tmo", 65'(timeout_count_o), 65'h0);
    check("rst_hdata", 65'(m_hdr_tdata), 65'h0);
    check("rst_pdata", 65'(m_payload_tdata), 65'h0);
    check("rst_keep", 65'(m_payload_tkeep), 65'hFF);
    aresetn = 1'b1;
    @(negedge aclk);
    check("idle_tready", {64'h0, s_axis_tready}, 65'h1);
    clear_q();

    // Write request
    send_word({32'h0A000001, 16'h1234, 16'd8}, 4'b0010, 1'b0);
    send_word({32'hCAFEBABE, 32'h00000010}, 4'b1100, 1'b1);
    wait_for(1, 1);
    check("wr_hdr", q_at(0, 0), {1'b0, 64'h0A000001_1234_0008});
    check("wr_pl", q_at(1, 0), {1'b1, 64'hCAFEBABE_00000010});
    check("wr_nacc", 65'(acc_q.size()), 65'd1);
    check("wr_acc", q_at(2, 0), {1'b1, 32'hCAFEBABE, 32'h00000010});
    clear_q();

    // Read of both halves
    send_word({32'h0A000002, 16'h5678, 16'd8}, 4'b0011, 1'b0);
    send_word({32'h00000008, 32'h00000004}, 4'b1101, 1'b1);
    wait_for(1, 2);
    check("rd2_hdr", q_at(0, 0), {1'b1, 64'h0A000002_5678_0010});
    check("rd2_pl0", q_at(1, 0), {1'b0, 64'hD0000004_00000004});
    check("rd2_pl1", q_at(1, 1), {1'b1, 64'hD0000008_00000008});
    check("rd2_acc0", q_at(2, 0), {1'b0, 32'h0, 32'h00000004});
    check("rd2_acc1", q_at(2, 1), {1'b0, 32'h0, 32'h00000008});
    clear_q();

    // Read, low half only
    send_word({32'h0A000003, 16'h0101, 16'd4}, 4'b0011, 1'b0);
    send_word({32'h00000000, 32'h00000020}, 4'b0101, 1'b1);
    wait_for(1, 1);
    check("rdlo_hdr", q_at(0, 0), {1'b1, 64'h0A000003_0101_0008});
    check("rdlo_pl", q_at(1, 0), {1'b1, 64'hD0000020_00000020});
    check("rdlo_nacc", 65'(acc_q.size()), 65'd1);
    clear_q();

    // Ack timeout
    ack_en    = 1'b0;
    en_cycles = 0;
    check("tmo_cnt0", 65'(timeout_count_o), 65'd0);
    send_word({32'h0A000004, 16'h0202, 16'd1}, 4'b0011, 1'b0);
    send_word({32'h00000000, 32'h00000030}, 4'b0101, 1'b1);
    wait_for(1, 1);
    check("tmo_hdr", q_at(0, 0), {1'b1, 64'h0A000004_0202_0002});
    check("tmo_pl", q_at(1, 0), {1'b1, 64'hFFFFFFFF_00000030});
    check("tmo_en_cycles", 65'(en_cycles), 65'd255);
    check("tmo_cnt1", 65'(timeout_count_o), 65'd1);
    check("tmo_nacc", 65'(acc_q.size()), 65'd0);
    ack_en = 1'b1;
    clear_q();

    // Payload backpressure
    m_payload_tready = 1'b0;
    send_word({32'h0A000005, 16'h0303, 16'd8}, 4'b0011, 1'b0);
    send_word({32'h00000044, 32'h00000040}, 4'b1101, 1'b1);
    n = 0;
    while (!m_payload_tvalid && n < 200) begin
      @(negedge aclk);
      n++;
    end
    first_data = m_payload_tdata;
    hold_ok    = 1'b1;
    repeat (20) begin
      @(negedge aclk);
      if (!m_payload_tvalid || m_payload_tdata !== first_data || en_o || s_axis_tready)
        hold_ok = 1'b0;
    end
    check("bp_data", {m_payload_tlast, m_payload_tdata}, {1'b0, 64'hD0000040_00000040});
    check("bp_hold", {64'h0, hold_ok}, 65'h1);
    check("bp_nacc", 65'(acc_q.size()), 65'd1);
    @(posedge aclk);
    #1;
    m_payload_tready = 1'b1;
    wait_for(1, 2);
    check("bp_hdr", q_at(0, 0), {1'b1, 64'h0A000005_0303_0010});
    check("bp_pl0", q_at(1, 0), {1'b0, 64'hD0000040_00000040});
    check("bp_pl1", q_at(1, 1), {1'b1, 64'hD0000044_00000044});
    check("bp_acc1", q_at(2, 1), {1'b0, 32'h0, 32'h00000044});
    clear_q();

    // Stray words without a header, then a normal write
    send_word(64'h1111_1111_0000_0001, 4'b0000, 1'b0);
    send_word(64'h2222_2222_0000_0002, 4'b1100, 1'b0);
    send_word(64'h3333_3333_0000_0003, 4'b1100, 1'b1);
    send_word({32'h0A000006, 16'h0404, 16'd4}, 4'b0010, 1'b0);
    send_word({32'h12345678, 32'h00000050}, 4'b1100, 1'b1);
    wait_for(1, 1);
    check("drop_nacc", 65'(acc_q.size()), 65'd1);
    check("drop_acc", q_at(2, 0), {1'b1, 32'h12345678, 32'h00000050});
    check("drop_hdr", q_at(0, 0), {1'b0, 64'h0A000006_0404_0004});
    check("drop_pl", q_at(1, 0), {1'b1, 64'h12345678_00000050});
    clear_q();

    // Header-only request with length 0
    send_word({32'h0A000007, 16'h0505, 16'd0}, 4'b0010, 1'b1);
    wait_for(1, 0);
    repeat (10) @(negedge aclk);
    check("len0_hdr", q_at(0, 0), {1'b0, 64'h0A000007_0505_0000});
    check("len0_npl", 65'(pl_q.size()), 65'd0);
    clear_q();

    // Write with only one half valid is skipped
    send_word({32'h0A000008, 16'h0606, 16'd8}, 4'b0010, 1'b0);
    send_word({32'hAAAA5555, 32'h00000080}, 4'b0100, 1'b1);
    wait_for(1, 0);
    repeat (10) @(negedge aclk);
    check("skip_hdr", q_at(0, 0), {1'b0, 64'h0A000008_0606_0008});
    check("skip_nacc", 65'(acc_q.size()), 65'd0);
    check("skip_npl", 65'(pl_q.size()), 65'd0);
    check("skip_idle", {64'h0, s_axis_tready}, 65'h1);
    clear_q();

    // Reset in the middle of an access
    ack_en = 1'b0;
    send_word({32'h0A000009, 16'h0707, 16'd1}, 4'b0011, 1'b0);
    send_word({32'h00000000, 32'h00000060}, 4'b0101, 1'b1);
    n = 0;
    while (!en_o && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("rsta_en_hi", {64'h0, en_o}, 65'h1);
    repeat (5) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("rsta_en_lo", {64'h0, en_o}, 65'h0);
    check("rsta_tmo", 65'(timeout_count_o), 65'd0);
    check("rsta_npl", 65'(pl_q.size()), 65'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    ack_en  = 1'b1;
    clear_q();
    send_word({32'h0A00000A, 16'h0808, 16'd8}, 4'b0010, 1'b0);
    send_word({32'h0BADF00D, 32'h00000070}, 4'b1100, 1'b1);
    wait_for(1, 1);
    check("post_hdr", q_at(0, 0), {1'b0, 64'h0A00000A_0808_0008});
    check("post_acc", q_at(2, 0), {1'b1, 32'h0BADF00D, 32'h00000070});
    check("post_pl", q_at(1, 0), {1'b1, 64'h0BADF00D_00000070});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
